// File: rtl/prog_ctr_pkg.sv
// Shared types and defaults for the program counter / fetch address generator.
package prog_ctr_pkg;

    localparam int unsigned DEF_PC_W  = 10;
    localparam int unsigned DEF_REL_W = 6;

    typedef logic [DEF_PC_W-1:0] pc_t;

    localparam pc_t DEF_START_ADDR = pc_t'(0);

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

endpackage

// File: rtl/prog_ctr_next.sv
// Combinational next-PC select: absolute branch, flag-gated relative branch, or increment.
module prog_ctr_next #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned REL_W = 6
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             abs_en,
    input  logic             rel_en,
    input  logic             alu_flag,
    input  logic [REL_W-1:0] rel_target,
    input  logic [PC_W-1:0]  abs_target,
    output logic [PC_W-1:0]  next_pc_c
);

    logic [PC_W-1:0] rel_sext;

    // Offset is relative to the current PC; sums wrap modulo 2^PC_W.
    assign rel_sext = PC_W'($signed(rel_target));

    always_comb begin
        next_pc_c = pc + PC_W'(1);
        if (abs_en) begin
            next_pc_c = abs_target;
        end else if (rel_en && !alu_flag) begin
            next_pc_c = pc + rel_sext;
        end
    end

endmodule

// File: rtl/prog_ctr.sv
// Program counter: idles after reset, holds the entry point while Start is high,
// then advances one instruction per cycle with absolute/relative branching.
module prog_ctr
    import prog_ctr_pkg::*;
#(
    parameter int unsigned         PC_W       = DEF_PC_W,
    parameter int unsigned         REL_W      = DEF_REL_W,
    parameter logic [PC_W-1:0]     START_ADDR = PC_W'(DEF_START_ADDR)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             BranchAbsEn,
    input  logic             BranchRelEn,
    input  logic             ALU_flag,
    input  logic [REL_W-1:0] RelTarget,
    input  logic [PC_W-1:0]  AbsTarget,
    output logic [PC_W-1:0]  ProgCtr
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] run_next_c;

    prog_ctr_next #(
        .PC_W  (PC_W),
        .REL_W (REL_W)
    ) u_next (
        .pc         (pc_q),
        .abs_en     (BranchAbsEn),
        .rel_en     (BranchRelEn),
        .alu_flag   (ALU_flag),
        .rel_target (RelTarget),
        .abs_target (AbsTarget),
        .next_pc_c  (run_next_c)
    );

    // Branch inputs only reach the PC in RUN; other states load or hold.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    pc_d    = START_ADDR;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                pc_d = START_ADDR;
                if (!Start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Start) begin
                    pc_d    = START_ADDR;
                    state_d = ST_ARMED;
                end else begin
                    pc_d = run_next_c;
                end
            end
            default: begin
                pc_d    = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign ProgCtr = pc_q;

endmodule

// File: tb/tb_prog_ctr.sv
// Directed self-checking bench for prog_ctr.
module tb_prog_ctr;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       BranchAbsEn;
    logic       BranchRelEn;
    logic       ALU_flag;
    logic [5:0] RelTarget;
    logic [9:0] AbsTarget;
    logic [9:0] ProgCtr;

    int checks;
    int errors;

    prog_ctr dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .BranchAbsEn (BranchAbsEn),
        .BranchRelEn (BranchRelEn),
        .ALU_flag    (ALU_flag),
        .RelTarget   (RelTarget),
        .AbsTarget   (AbsTarget),
        .ProgCtr     (ProgCtr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [9:0] exp);
        checks++;
        assert (ProgCtr === exp)
        else begin
            errors++;
            $error("FAIL %s: ProgCtr=%0d expected=%0d", tag, ProgCtr, exp);
        end
    endtask

    task automatic edge_check(input string tag, input logic [9:0] exp);
        @(posedge Clk);
        #1;
        check(tag, exp);
    endtask

    task automatic set_br(input logic abs_en, input logic rel_en, input logic flag,
                          input logic [5:0] rel, input logic [9:0] abs_t);
        BranchAbsEn = abs_en;
        BranchRelEn = rel_en;
        ALU_flag    = flag;
        RelTarget   = rel;
        AbsTarget   = abs_t;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b0;
        Start  = 1'b0;
        set_br(1'b0, 1'b0, 1'b0, 6'd0, 10'd0);

        // Reset and idle
        #12;
        check("reset", 10'd0);
        Reset = 1'b1;
        edge_check("idle0", 10'd0);
        edge_check("idle1", 10'd0);

        // Start and launch
        Start = 1'b1;
        edge_check("armed", 10'd0);
        Start = 1'b0;
        edge_check("launch", 10'd0);
        edge_check("run1", 10'd1);
        edge_check("run2", 10'd2);

        // Absolute and relative branches
        set_br(1'b1, 1'b0, 1'b0, 6'd0, 10'd10);
        edge_check("abs10", 10'd10);
        set_br(1'b0, 1'b1, 1'b0, 6'd5, 10'd0);
        edge_check("rel5", 10'd15);
        set_br(1'b0, 1'b1, 1'b1, 6'd5, 10'd0);
        edge_check("rel_flag", 10'd16);
        set_br(1'b0, 1'b0, 1'b0, 6'd0, 10'd0);
        edge_check("inc17", 10'd17);
        set_br(1'b0, 1'b1, 1'b0, 6'b111011, 10'd0);
        edge_check("rel_m5", 10'd12);
        set_br(1'b1, 1'b1, 1'b0, 6'd5, 10'd100);
        edge_check("both", 10'd100);

        // Wrap-around
        set_br(1'b1, 1'b0, 1'b0, 6'd0, 10'd1023);
        edge_check("abs1023", 10'd1023);
        set_br(1'b0, 1'b0, 1'b0, 6'd0, 10'd0);
        edge_check("wrap0", 10'd0);
        edge_check("wrap1", 10'd1);
        edge_check("wrap2", 10'd2);
        set_br(1'b0, 1'b1, 1'b0, 6'b111100, 10'd0);
        edge_check("rel_m4", 10'd1022);
        set_br(1'b0, 1'b1, 1'b0, 6'd0, 10'd0);
        edge_check("rel0", 10'd1022);
        set_br(1'b0, 1'b1, 1'b0, 6'd31, 10'd0);
        edge_check("rel31", 10'd29);

        // Restart from RUN; branches ignored while ARMED
        Start = 1'b1;
        set_br(1'b1, 1'b0, 1'b0, 6'd0, 10'd77);
        edge_check("restart", 10'd0);
        Start = 1'b0;
        edge_check("relaunch", 10'd0);
        set_br(1'b0, 1'b0, 1'b0, 6'd0, 10'd0);
        edge_check("rerun1", 10'd1);
        set_br(1'b1, 1'b0, 1'b0, 6'd0, 10'd40);
        edge_check("abs40", 10'd40);

        // Asynchronous reset mid-cycle, then idle with branches ignored
        set_br(1'b1, 1'b1, 1'b0, 6'd3, 10'd55);
        #2;
        Reset = 1'b0;
        #1;
        check("async_rst", 10'd0);
        edge_check("in_rst", 10'd0);
        Reset = 1'b1;
        edge_check("post_rst0", 10'd0);
        edge_check("post_rst1", 10'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
